// File: rtl/add.sv
// add: registered ripple-carry adder producing the wrapped sum plus carry, overflow, zero and negative flags
module add #(
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Add_Result,
  output logic             Carry_Out,
  output logic             Overflow,
  output logic             Zero,
  output logic             Negative
);
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;
  assign w_c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign w_sum[i]  = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1]  = (A[i] & B[i]) | (A[i] & w_c[i]) | (B[i] & w_c[i]);
  end
  // Signed overflow: like-signed operands whose sum flips sign.
  assign w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b1;
      r_neg   <= 1'b0;
    end else begin
      r_sum   <= w_sum;
      r_carry <= w_c[WIDTH];
      r_ovf   <= w_ovf;
      r_zero  <= (w_sum == '0);
      r_neg   <= w_sum[WIDTH-1];
    end
  end
  assign Add_Result = r_sum;
  assign Carry_Out  = r_carry;
  assign Overflow   = r_ovf;
  assign Zero       = r_zero;
  assign Negative   = r_neg;
endmodule

// File: tb/tb_add.sv
// tb_add: directed and random checks of the registered adder and its flags
module tb_add;
  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] A;
  logic [5:0] B;
  logic [5:0] Add_Result;
  logic       Carry_Out;
  logic       Overflow;
  logic       Zero;
  logic       Negative;
  int checks = 0;
  int errors = 0;

  add #(.WIDTH(6)) dut (
    .clock(clock), .reset(reset), .A(A), .B(B), .Add_Result(Add_Result),
    .Carry_Out(Carry_Out), .Overflow(Overflow), .Zero(Zero), .Negative(Negative)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic [5:0] a, input logic [5:0] b);
    @(negedge clock);
    reset = rst;
    A = a;
    B = b;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [5:0] s, input logic c, input logic v,
                         input logic z, input logic n);
    chk({tag, ".sum"}, Add_Result, s);
    chk({tag, ".carry"}, {5'b0, Carry_Out}, {5'b0, c});
    chk({tag, ".ovf"}, {5'b0, Overflow}, {5'b0, v});
    chk({tag, ".zero"}, {5'b0, Zero}, {5'b0, z});
    chk({tag, ".neg"}, {5'b0, Negative}, {5'b0, n});
  endtask

  initial begin
    logic [5:0] a, b;
    logic [6:0] s;
    reset = 1'b1;
    A = 6'b011111;
    B = 6'b000001;
    apply(1'b1, 6'b011111, 6'b000001);
    apply(1'b1, 6'b011111, 6'b000001);
    chk_all("reset", 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 6'b011111, 6'b000001);
    chk_all("release", 6'b100000, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(1'b0, 6'b000001, 6'b101111);
    chk_all("no_ovf", 6'b110000, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 6'b011001, 6'b011001);
    chk_all("pos_ovf", 6'b110010, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(1'b0, 6'b101101, 6'b101111);
    chk_all("neg_ovf", 6'b011100, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 6'b111111, 6'b000001);
    chk_all("zero_carry", 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 6'b111111, 6'b111111);
    chk_all("max_unsigned", 6'b111110, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 6'b100000, 6'b100000);
    chk_all("min_plus_min", 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 6'b000000, 6'b000000);
    chk_all("zero_zero", 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 6'b010101, 6'b001010);
    chk_all("b2b_1", 6'b011111, 1'b0, 1'b0, 1'b0, 1'b0);
    // Output must hold its value until the next rising edge even as operands change.
    @(negedge clock);
    A = 6'b000011;
    B = 6'b000100;
    #1;
    chk_all("hold", 6'b011111, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    chk_all("b2b_2", 6'b000111, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 6'b110000, 6'b110000);
    chk_all("mid_reset", 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 6'b110000, 6'b110000);
    chk_all("post_reset", 6'b100000, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      a = 6'($urandom_range(0, 63));
      b = 6'($urandom_range(0, 63));
      s = {1'b0, a} + {1'b0, b};
      apply(1'b0, a, b);
      chk_all("rand", s[5:0], s[6], (a[5] == b[5]) && (s[5] != a[5]), s[5:0] == 6'd0, s[5]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
